// File: rtl/dxi_pkg.sv
// rtl/dxi_pkg.sv - shared widths, types and round-robin pick helper for the dxi filter arbiter
package dxi_pkg;

  localparam int DXI_DATA_W = 72;
  localparam int DXI_PIX_W  = 8;
  localparam int DXI_CFG_W  = 2;
  localparam int RR_MAX     = 8;

  typedef logic [DXI_PIX_W-1:0]  pixel_t;
  typedef logic [DXI_DATA_W-1:0] window_t;
  typedef logic [DXI_CFG_W-1:0]  cfg_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First valid index strictly after ptr, wrapping over n requesters.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [2:0] ptr,
                                       input int n);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 1; i <= RR_MAX; i++) begin
      k = (int'(ptr) + i) % n;
      if (i <= n && !r.found && valid[k[2:0]]) begin
        r.found = 1'b1;
        r.idx   = k[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dxi_tag_fifo.sv
// rtl/dxi_tag_fifo.sv - grant-order tag FIFO linking filter responses back to requesters
module dxi_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [WIDTH-1:0]               i_din,
  output logic [WIDTH-1:0]               o_dout,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign o_dout  = mem_q[rd_q];

  always_comb begin
    do_push = i_push & ~o_full;
    do_pop  = i_pop & ~o_empty;
    wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = do_pop ? rd_q + PTR_W'(1) : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dxi_filter_arbiter.sv
// rtl/dxi_filter_arbiter.sv - round-robin sharing of one 3x3 filter among N_REQ requesters
module dxi_filter_arbiter
  import dxi_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rstn,
  input  logic [N_REQ-1:0]                 i_req_valid,
  input  logic [N_REQ*DXI_DATA_W-1:0]      i_req_data,
  input  logic [N_REQ*DXI_CFG_W-1:0]       i_req_cfg,
  output logic [N_REQ-1:0]                 o_req_ready,
  output logic                             o_flt_valid,
  output logic [DXI_DATA_W-1:0]            o_flt_data,
  output logic [DXI_CFG_W-1:0]             o_flt_cfg,
  input  logic                             i_flt_ready,
  input  logic                             i_flt_out_valid,
  input  logic [DXI_PIX_W-1:0]             i_flt_out_data,
  output logic                             o_flt_out_ready,
  output logic [N_REQ-1:0]                 o_rsp_valid,
  output logic [DXI_PIX_W-1:0]             o_rsp_data,
  input  logic [N_REQ-1:0]                 i_rsp_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   o_inflight,
  output logic                             o_err_orphan
);

  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic              flt_valid_q, flt_valid_d;
  window_t           flt_data_q, flt_data_d;
  cfg_t              flt_cfg_q, flt_cfg_d;
  logic [2:0]        ptr_q, ptr_d;
  logic              err_q, err_d;

  logic [RR_MAX-1:0] valid_ext;
  rr_pick_t          pick;
  logic              slot_free, can_grant, grant;
  window_t           sel_data;
  cfg_t              sel_cfg;
  logic [TAG_W-1:0]  sel_tag, head;
  logic              fifo_full, fifo_empty, rsp_ready_head, pop;

  dxi_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (grant),
    .i_pop   (pop),
    .i_din   (sel_tag),
    .o_dout  (head),
    .o_count (o_inflight),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // A full tag FIFO blocks grants even if a pop lands in the same cycle.
  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = i_req_valid;
    pick                   = rr_pick(valid_ext, ptr_q, N_REQ);
    slot_free              = ~flt_valid_q | i_flt_ready;
    can_grant              = i_rstn & slot_free & ~fifo_full;
    grant                  = can_grant & pick.found;
    o_req_ready            = '0;
    sel_data               = '0;
    sel_cfg                = '0;
    sel_tag                = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick.idx == 3'(k)) begin
        o_req_ready[k] = grant;
        sel_data       = i_req_data[k*DXI_DATA_W +: DXI_DATA_W];
        sel_cfg        = i_req_cfg[k*DXI_CFG_W +: DXI_CFG_W];
        sel_tag        = TAG_W'(k);
      end
    end

    flt_valid_d = flt_valid_q;
    flt_data_d  = flt_data_q;
    flt_cfg_d   = flt_cfg_q;
    ptr_d       = ptr_q;
    if (grant) begin
      flt_valid_d = 1'b1;
      flt_data_d  = sel_data;
      flt_cfg_d   = sel_cfg;
      ptr_d       = pick.idx;
    end else if (slot_free) begin
      flt_valid_d = 1'b0;
    end
  end

  always_comb begin
    o_rsp_valid    = '0;
    rsp_ready_head = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (head == TAG_W'(k)) begin
        o_rsp_valid[k] = i_flt_out_valid & ~fifo_empty;
        rsp_ready_head = i_rsp_ready[k];
      end
    end
    o_rsp_data      = i_flt_out_data;
    o_flt_out_ready = ~fifo_empty & rsp_ready_head;
    pop             = i_flt_out_valid & o_flt_out_ready;
    err_d           = err_q | (i_flt_out_valid & fifo_empty);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      flt_valid_q <= 1'b0;
      flt_data_q  <= '0;
      flt_cfg_q   <= '0;
      ptr_q       <= 3'(N_REQ - 1);
      err_q       <= 1'b0;
    end else begin
      flt_valid_q <= flt_valid_d;
      flt_data_q  <= flt_data_d;
      flt_cfg_q   <= flt_cfg_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign o_flt_valid  = flt_valid_q;
  assign o_flt_data   = flt_data_q;
  assign o_flt_cfg    = flt_cfg_q;
  assign o_err_orphan = err_q;

endmodule

// File: tb/tb_dxi_filter_arbiter.sv
// tb/tb_dxi_filter_arbiter.sv - scoreboard bench for dxi_filter_arbiter with a min-of-window filter stub
module tb_dxi_filter_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           i_rstn = 1'b0;
  logic [N-1:0]   i_req_valid = '0;
  logic [N*72-1:0] i_req_data = '0;
  logic [N*2-1:0] i_req_cfg = '0;
  logic [N-1:0]   o_req_ready;
  logic           o_flt_valid;
  logic [71:0]    o_flt_data;
  logic [1:0]     o_flt_cfg;
  logic           i_flt_ready = 1'b1;
  logic           i_flt_out_valid = 1'b0;
  logic [7:0]     i_flt_out_data = '0;
  logic           o_flt_out_ready;
  logic [N-1:0]   o_rsp_valid;
  logic [7:0]     o_rsp_data;
  logic [N-1:0]   i_rsp_ready = '1;
  logic [2:0]     o_inflight;
  logic           o_err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  logic [73:0] rq [N][$];
  logic [3:0]  exp_grant [$];
  logic [11:0] exp_rsp [$];
  logic [73:0] exp_flt [$];
  logic [7:0]  stub_q [$];
  bit          resp_en = 1'b1;
  bit          orphan_force = 1'b0;

  always #5 clk = ~clk;

  dxi_filter_arbiter #(.N_REQ(N), .TAG_DEPTH(4)) dut (
    .i_clk           (clk),
    .i_rstn          (i_rstn),
    .i_req_valid     (i_req_valid),
    .i_req_data      (i_req_data),
    .i_req_cfg       (i_req_cfg),
    .o_req_ready     (o_req_ready),
    .o_flt_valid     (o_flt_valid),
    .o_flt_data      (o_flt_data),
    .o_flt_cfg       (o_flt_cfg),
    .i_flt_ready     (i_flt_ready),
    .i_flt_out_valid (i_flt_out_valid),
    .i_flt_out_data  (i_flt_out_data),
    .o_flt_out_ready (o_flt_out_ready),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_data      (o_rsp_data),
    .i_rsp_ready     (i_rsp_ready),
    .o_inflight      (o_inflight),
    .o_err_orphan    (o_err_orphan)
  );

  task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] min9(input logic [71:0] w);
    logic [7:0] m;
    m = w[7:0];
    for (int i = 1; i < 9; i++) if (w[i*8 +: 8] < m) m = w[i*8 +: 8];
    return m;
  endfunction

  // Requesters: hold valid/data until ready is seen, then advance.
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = o_req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && rq[k].size() > 0) rq[k].delete(0);
        if (rq[k].size() > 0) begin
          i_req_valid[k]        = 1'b1;
          i_req_data[k*72 +: 72] = rq[k][0][73:2];
          i_req_cfg[k*2 +: 2]    = rq[k][0][1:0];
        end else begin
          i_req_valid[k] = 1'b0;
        end
      end
    end
  end

  // Filter stub: returns the minimum byte of each accepted window, in order.
  initial begin
    logic        acc_in, acc_out;
    logic [71:0] din;
    forever begin
      @(negedge clk);
      acc_in  = o_flt_valid & i_flt_ready;
      din     = o_flt_data;
      acc_out = i_flt_out_valid & o_flt_out_ready;
      @(posedge clk);
      #1;
      if (!i_rstn) begin
        stub_q.delete();
      end else begin
        if (acc_out && stub_q.size() > 0) stub_q.delete(0);
        if (acc_in) stub_q.push_back(min9(din));
      end
      i_flt_out_valid = orphan_force | (resp_en & (stub_q.size() > 0));
      i_flt_out_data  = orphan_force ? 8'h5A : ((stub_q.size() > 0) ? stub_q[0] : 8'h00);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a grant, filter beat or response.
  initial begin
    logic [3:0]  e4;
    logic [11:0] e12;
    logic [73:0] e74;
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      if (i_rstn) begin
        if (o_req_ready != '0) begin
          if (exp_grant.size() == 0) chk("grant_unexpected", 74'(o_req_ready), 74'd0);
          else begin
            e4 = exp_grant.pop_front();
            chk("grant_order", 74'(o_req_ready), 74'(e4));
          end
        end
        if (o_flt_valid && i_flt_ready) begin
          if (exp_flt.size() == 0) chk("flt_unexpected", 74'(o_flt_valid), 74'd0);
          else begin
            e74 = exp_flt.pop_front();
            chk("flt_data", 74'(o_flt_data), 74'(e74[73:2]));
            chk("flt_cfg", 74'(o_flt_cfg), 74'(e74[1:0]));
          end
        end
        hs = o_rsp_valid & i_rsp_ready;
        if (hs != '0) begin
          if (exp_rsp.size() == 0) chk("rsp_unexpected", 74'(hs), 74'd0);
          else begin
            e12 = exp_rsp.pop_front();
            chk("rsp_route", 74'(hs), 74'(e12[11:8]));
            chk("rsp_data", 74'(o_rsp_data), 74'(e12[7:0]));
          end
        end
      end
    end
  end

  task automatic expect_txn(input int k, input logic [71:0] d, input logic [1:0] c,
                            input logic [7:0] px, input bit with_rsp);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    rq[k].push_back({d, c});
    exp_grant.push_back(oh);
    exp_flt.push_back({d, c});
    if (with_rsp) exp_rsp.push_back({oh, px});
  endtask

  task automatic wait_grant(output logic [3:0] g);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_req_ready == '0 && t < 50);
    g = o_req_ready;
    chk("grant_seen", 74'(o_req_ready != '0), 74'd1);
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while ((exp_grant.size() + exp_rsp.size() + exp_flt.size()) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 74'(exp_grant.size() + exp_rsp.size() + exp_flt.size()), 74'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  g;
    logic [71:0] t2d [4];
    logic [7:0]  t2m [4];
    int          ord [8];
    int          t;
    logic [71:0] x0;

    t2d[0] = 72'h010203040506070809;  t2m[0] = 8'h01;
    t2d[1] = {9{8'h40}};              t2m[1] = 8'h40;
    t2d[2] = 72'h112233445566778899;  t2m[2] = 8'h11;
    t2d[3] = {9{8'hFF}};              t2m[3] = 8'hFF;
    ord = '{2, 3, 0, 1, 2, 3, 0, 1};
    x0 = 72'hDEADBEEF0123456789;

    // Reset state, with requester 1 already valid
    expect_txn(1, 72'h000102030405060708, 2'b00, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 74'(o_req_ready), 74'd0);
    chk("rst_flt_valid", 74'(o_flt_valid), 74'd0);
    chk("rst_flt_data", 74'(o_flt_data), 74'd0);
    chk("rst_flt_cfg", 74'(o_flt_cfg), 74'd0);
    chk("rst_inflight", 74'(o_inflight), 74'd0);
    chk("rst_orphan", 74'(o_err_orphan), 74'd0);
    chk("rst_rsp_valid", 74'(o_rsp_valid), 74'd0);
    chk("rst_out_ready", 74'(o_flt_out_ready), 74'd0);
    @(posedge clk); #1; i_rstn = 1'b1;

    // Single request from requester 1
    wait_grant(g);
    chk("t1_grant", 74'(g), 74'(4'b0010));
    @(negedge clk);
    chk("t1_flt_valid", 74'(o_flt_valid), 74'd1);
    chk("t1_flt_cfg", 74'(o_flt_cfg), 74'd0);
    chk("t1_ready_one_cycle", 74'(o_req_ready), 74'd0);
    wait_drain("t1_drain");

    // All four requesters, two rounds, back-to-back grants
    for (int i = 0; i < 8; i++) expect_txn(ord[i], t2d[ord[i]], 2'(ord[i]), t2m[ord[i]], 1'b1);
    wait_grant(g);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t2_back_to_back", 74'(o_req_ready != '0), 74'd1);
    end
    wait_drain("t2_drain");

    // Filter stall holds data; tag FIFO full blocks the fifth grant
    @(posedge clk); #1; i_flt_ready = 1'b0; resp_en = 1'b0;
    expect_txn(0, x0, 2'b10, 8'h01, 1'b1);
    wait_grant(g);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 74'(o_flt_valid), 74'd1);
      chk("t3_hold_data", 74'(o_flt_data), 74'(x0));
      chk("t3_inflight1", 74'(o_inflight), 74'd1);
    end
    expect_txn(1, {9{8'h40}}, 2'b01, 8'h40, 1'b1);
    expect_txn(2, 72'h112233445566778899, 2'b11, 8'h11, 1'b1);
    expect_txn(3, 72'h908070605040302010, 2'b00, 8'h10, 1'b1);
    expect_txn(0, {9{8'h7E}}, 2'b01, 8'h7E, 1'b1);
    repeat (3) @(negedge clk);
    chk("t3_stall_no_grant", 74'(o_req_ready), 74'd0);
    @(posedge clk); #1; i_flt_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t3_inflight_full", 74'(o_inflight), 74'd4);
    chk("t3_full_blocks", 74'(o_req_ready), 74'd0);
    chk("t3_flt_idle", 74'(o_flt_valid), 74'd0);
    @(posedge clk); #1; resp_en = 1'b1;
    wait_drain("t3_drain");
    chk("t3_inflight_end", 74'(o_inflight), 74'd0);

    // Response back-pressure from requester 3
    @(posedge clk); #1; i_rsp_ready = 4'b0111;
    expect_txn(3, {9{8'hA5}}, 2'b11, 8'hA5, 1'b1);
    wait_grant(g);
    repeat (4) @(negedge clk);
    chk("t4_rsp_valid", 74'(o_rsp_valid), 74'(4'b1000));
    chk("t4_out_ready", 74'(o_flt_out_ready), 74'd0);
    chk("t4_rsp_data", 74'(o_rsp_data), 74'(8'hA5));
    chk("t4_inflight", 74'(o_inflight), 74'd1);
    @(posedge clk); #1; i_rsp_ready = '1;
    wait_drain("t4_drain");
    chk("t4_inflight_end", 74'(o_inflight), 74'd0);

    // Orphan response
    @(posedge clk); #1; orphan_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_orphan_set", 74'(o_err_orphan), 74'd1);
    chk("t5_no_rsp", 74'(o_rsp_valid), 74'd0);
    chk("t5_out_ready", 74'(o_flt_out_ready), 74'd0);
    @(posedge clk); #1; orphan_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_orphan_sticky", 74'(o_err_orphan), 74'd1);

    // Reset with three transactions in flight
    @(posedge clk); #1; resp_en = 1'b0;
    expect_txn(1, {9{8'h61}}, 2'b00, 8'h61, 1'b0);
    expect_txn(2, {9{8'h62}}, 2'b01, 8'h62, 1'b0);
    expect_txn(3, {9{8'h63}}, 2'b10, 8'h63, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_inflight != 3'd3 && t < 50);
    chk("t6_inflight3", 74'(o_inflight), 74'd3);
    @(negedge clk);
    #2; i_rstn = 1'b0;
    #1;
    chk("t6_rst_inflight", 74'(o_inflight), 74'd0);
    chk("t6_rst_flt_valid", 74'(o_flt_valid), 74'd0);
    chk("t6_rst_flt_data", 74'(o_flt_data), 74'd0);
    chk("t6_rst_orphan", 74'(o_err_orphan), 74'd0);
    chk("t6_rst_rsp_valid", 74'(o_rsp_valid), 74'd0);
    chk("t6_rst_out_ready", 74'(o_flt_out_ready), 74'd0);
    expect_txn(0, 72'h0F0E0D0C0B0A090807, 2'b00, 8'h07, 1'b1);
    expect_txn(3, 72'h333333333333333322, 2'b11, 8'h22, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_rst_ready_gated", 74'(o_req_ready), 74'd0);
    @(posedge clk); #1; i_rstn = 1'b1; resp_en = 1'b1;
    wait_grant(g);
    chk("t6_first_after_rst", 74'(g), 74'(4'b0001));
    wait_drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dxi_filter_arbiter.md
Name: dxi_filter_arbiter

Overview:
- Shares one dxi_top 3x3 filter instance between N_REQ independent requesters. Each requester supplies a 72-bit window and its own 2-bit config_select.
- Round-robin arbitration selects the next requester. A registered output stage drives the filter slave port.
- A tag FIFO records the grant order. Each 8-bit filter result is routed back to the requester that issued it.
- Sits between the stream sources and the dxi_top inputs and outputs. Pure control and buffering; no pixel arithmetic.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TAG_DEPTH, 4, maximum transactions in flight (granted but response not yet returned). Power of two, 2..16.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_req_valid  in  N_REQ  per-requester valid
- i_req_data  in  N_REQ*72  per-requester window; requester k at bits [72k+71:72k]
- i_req_cfg  in  N_REQ*2  per-requester config_select; requester k at bits [2k+1:2k]
- o_req_ready  out  N_REQ  one-hot grant/accept
- o_flt_valid  out  1  to dxi_top i_dxi_valid
- o_flt_data  out  72  to dxi_top i_dxi_data
- o_flt_cfg  out  2  to dxi_top config_select
- i_flt_ready  in  1  from dxi_top o_dxi_ready
- i_flt_out_valid  in  1  from dxi_top o_dxi_out_valid
- i_flt_out_data  in  8  from dxi_top o_master_data
- o_flt_out_ready  out  1  to dxi_top i_dxi_out_ready
- o_rsp_valid  out  N_REQ  one-hot response valid
- o_rsp_data  out  8  response pixel, shared by all requesters
- i_rsp_ready  in  N_REQ  per-requester response ready
- o_inflight  out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy
- o_err_orphan  out  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): o_flt_valid=0, o_flt_data=0, o_flt_cfg=0, o_inflight=0, o_err_orphan=0, tag FIFO empty. Round-robin pointer = N_REQ-1, so requester 0 has first priority.
- Combinational outputs during reset: o_req_ready=0, o_rsp_valid=0, o_flt_out_ready=0.
- Request side:
  - slot_free = ~o_flt_valid | i_flt_ready.
  - can_grant = slot_free & (o_inflight < TAG_DEPTH).
  - When can_grant is true, the grant g is the first k with i_req_valid[k]=1, searching from ptr+1 upward and wrapping.
  - o_req_ready[g]=1 combinationally in that cycle only; all other bits are 0.
  - On a grant edge: o_flt_data/o_flt_cfg load requester g's data and cfg, o_flt_valid=1, tag g is pushed, ptr=g.
  - If slot_free holds and no requester is valid, o_flt_valid clears to 0.
  - While o_flt_valid=1 and i_flt_ready=0, o_flt_data and o_flt_cfg stay stable (AXI-style hold).
  - Latency: request accept to o_flt_valid is 1 cycle. Sustained throughput is 1 transaction per cycle.
- Response side:
  - head = tag at the FIFO head.
  - o_rsp_valid[head] = i_flt_out_valid & ~empty.
  - o_rsp_data = i_flt_out_data, combinational.
  - o_flt_out_ready = ~empty & i_rsp_ready[head].
  - Pop on i_flt_out_valid & o_flt_out_ready.
- Orphan response: if the FIFO is empty while i_flt_out_valid=1, then o_flt_out_ready=0, no o_rsp_valid is raised, and o_err_orphan is set. It stays set until reset.
- Push and pop in the same cycle: o_inflight is unchanged and ordering is preserved. This includes the full case, where a pop frees the slot combinationally? No — can_grant uses registered o_inflight, so a full FIFO blocks grants even when a pop occurs in that cycle. This is a decided one-cycle bubble.
- Pointer wrap-around: after N_REQ-1 is granted, requester 0 has priority next.
- Requesters must hold valid and data until their ready bit is seen. The arbiter does not drop a valid request.
- Reset mid-operation: all in-flight tags are discarded. The filter must be reset together with the arbiter.

Decomposition:
- Package dxi_pkg:
  - Constants: DXI_DATA_W=72, DXI_PIX_W=8, DXI_CFG_W=2.
  - Typedefs: pixel_t, window_t (logic [DXI_DATA_W-1:0]), cfg_t.
  - Function rr_pick(valid, ptr) returning the index plus a found bit.
- Sub-module dxi_tag_fifo:
  - Synchronous FIFO; width $clog2(N_REQ), depth TAG_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same clock and async active-low reset as the arbiter.

Test Plan:
- Single requester 1 sends 72'h000102030405060708 with cfg 2'b00 → o_req_ready=4'b0010 for one cycle. o_flt_valid goes high the next cycle with o_flt_cfg=0. The filter result 8'h00 appears on o_rsp_valid=4'b0010.
- All 4 requesters valid continuously, cfgs 00/01/10/11, filter always ready → grants in order 0,1,2,3,0… with one grant per cycle. Each response returns to its own requester; a requester with all-FF data receives 8'hFF.
- i_flt_ready held 0 for 5 cycles after a grant → o_flt_data stays stable and o_inflight=1. Further grants stop once o_inflight reaches 4; the 5th requester waits until a response is popped.
- i_rsp_ready[head]=0 with i_flt_out_valid=1 → o_flt_out_ready=0 and the FIFO is not popped. Releasing ready pops it with data intact, e.g. 8'hA5 to requester 3.
- Filter drives i_flt_out_valid=1 with no transactions in flight → o_err_orphan=1 and stays set. o_rsp_valid remains 0.
- Assert i_rstn low with 3 transactions in flight → all outputs return to reset values immediately. After release, requester 0 wins the first arbitration.
